// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic CPU pipeline stage.
// Holds the stage state encoding and the NOP used as flush payload.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_FULL
    } pipe_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
// Used for the optional downstream-blocked cycle count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipe register with 2-entry skid, stall and flush.
// Optional stall counter port enabled by macro PIPE_STALL_CNT_EN.
module pipe_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] q_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    pipe_state_e      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             acc;
    logic             emit;

    // ready_o depends on state only, so backpressure never ripples upstream
    assign ready_o = (state != PS_FULL);
    assign valid_o = (state != PS_EMPTY);
    assign q_o     = main_q;
    assign acc     = valid_i & ready_o;
    assign emit    = valid_o & ready_i & ~stall_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= PS_EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (flush_i) begin
            state  <= PS_EMPTY;
            main_q <= FLUSH_VAL;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (acc) begin
                        state  <= PS_ONE;
                        main_q <= d_i;
                    end
                end
                PS_ONE: begin
                    if (acc && emit) begin
                        main_q <= d_i;
                    end else if (acc) begin
                        state  <= PS_FULL;
                        skid_q <= d_i;
                    end else if (emit) begin
                        state <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (emit) begin
                        state  <= PS_ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= PS_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en     (valid_o & ~(ready_i & ~stall_i)),
        .clear  (1'b0),
        .count  (stall_cnt_o)
    );
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic against a queue model.
// Checks PIPE_STALL_CNT_EN counter when that macro is defined.
module tb_pipe_stage_elastic;

    localparam int          W     = 32;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;
    localparam logic [31:0] FV    = 32'h0000_0013;
    localparam int          CNT_W = 4;

    logic         clk = 1'b0;
    logic         reset_i, flush_i, stall_i, valid_i, ready_i;
    logic [W-1:0] d_i;
    logic         ready_o, valid_o;
    logic [W-1:0] q_o;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o;
`endif

    int passed = 0;
    int total  = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] mlast;
    int           mcnt;

    pipe_stage_elastic #(
        .WIDTH    (W),
        .RESET_VAL(RV),
        .FLUSH_VAL(FV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .stall_i(stall_i),
        .valid_i(valid_i),
        .d_i    (d_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .q_o    (q_o)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_o"}, {31'b0, valid_o}, {31'b0, mq.size() != 0});
        chk({tag, ".ready_o"}, {31'b0, ready_o}, {31'b0, mq.size() != 2});
        chk({tag, ".q_o"}, q_o, mlast);
`ifdef PIPE_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt_o}, mcnt);
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, check at negedge
    task automatic cyc(input logic v, input logic [W-1:0] dd, input logic r,
                       input logic s, input logic f, input string tag);
        bit acc, emit;
        valid_i = v; d_i = dd; ready_i = r; stall_i = s; flush_i = f;
        @(posedge clk);
        acc  = v && (mq.size() < 2);
        emit = (mq.size() > 0) && r && !s;
        if ((mq.size() > 0) && !(r && !s) && (mcnt < (1 << CNT_W) - 1))
            mcnt++;
        if (f) begin
            mq.delete();
            mlast = FV;
        end else begin
            if (emit) void'(mq.pop_front());
            if (acc) mq.push_back(dd);
            if (mq.size() > 0) mlast = mq[0];
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 reset_i = 1'b1;
        #1;
        mq.delete();
        mlast = RV;
        mcnt  = 0;
        check_all(tag);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0; d_i = '0;
        mlast = RV; mcnt = 0;
        @(negedge clk);
        do_reset("reset0");

        // put data in flight, then reset mid-cycle
        cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, "pre_rst_a");
        cyc(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0, "pre_rst_b");
        do_reset("reset_mid");
        chk("reset_q_const", q_o, RV);

        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0, 1'b0, "stream");
            chk("stream_q", q_o, i);
            chk("stream_ready", {31'b0, ready_o}, 32'd1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "stream_drain");

        cyc(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, "bp_a");
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, "bp_b");
        chk("bp_full_ready", {31'b0, ready_o}, 32'd0);
        chk("bp_full_q", q_o, 32'hA);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "bp_out_b");
        chk("bp_second", q_o, 32'hB);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "bp_empty");

        cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, "stall_load");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h60 + i, 1'b1, 1'b1, 1'b0, "stall");
            chk("stall_q", q_o, 32'h55);
            chk("stall_valid", {31'b0, valid_o}, 32'd1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "stall_drain1");
        chk("stall_skid_out", q_o, 32'h60);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "stall_drain2");

        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, "fl_a");
        cyc(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, "fl_b");
        cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, "flush");
        chk("flush_q", q_o, FV);
        chk("flush_valid", {31'b0, valid_o}, 32'd0);
        chk("flush_ready", {31'b0, ready_o}, 32'd1);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_flush");

        do_reset("reset_cnt");
        cyc(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, "cnt_load");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, "cnt_block");
`ifdef PIPE_STALL_CNT_EN
        chk("cnt_ten", {{(32-CNT_W){1'b0}}, stall_cnt_o}, 32'd10);
`endif
        for (int i = 0; i < 10; i++)
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, "cnt_block2");
`ifdef PIPE_STALL_CNT_EN
        chk("cnt_sat", {{(32-CNT_W){1'b0}}, stall_cnt_o}, 32'd15);
`endif
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, "cnt_flush");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rand_reset");
            cyc(1'($urandom), $urandom, 1'($urandom),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
